// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// Ovf is present only when CLA_ADDER_OVF_EN is defined.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] F;
  logic             Cout;
`ifdef CLA_ADDER_OVF_EN
  logic             Ovf;

  modport master (
    output in_valid, A, B, Sub, Cin, out_ready,
    input  in_ready, out_valid, F, Cout, Ovf
  );
  modport slave (
    input  in_valid, A, B, Sub, Cin, out_ready,
    output in_ready, out_valid, F, Cout, Ovf
  );
`else
  modport master (
    output in_valid, A, B, Sub, Cin, out_ready,
    input  in_ready, out_valid, F, Cout
  );
  modport slave (
    input  in_valid, A, B, Sub, Cin, out_ready,
    output in_ready, out_valid, F, Cout
  );
`endif
endinterface

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit adder/subtractor built from 4-bit lookahead groups, one pipeline stage per group.
// Optional signed-overflow output enabled by defining CLA_ADDER_OVF_EN.
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int GROUPS = WIDTH / 4;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Returns {carry out, 4-bit sum} of one lookahead group.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] p;
    logic [3:0] gn;
    logic [4:0] c;
    p    = a ^ b;
    gn   = a & b;
    c[0] = ci;
    c[1] = gn[0] | (p[0] & ci);
    c[2] = gn[1] | (p[1] & gn[0]) | (p[1] & p[0] & ci);
    c[3] = gn[2] | (p[2] & gn[1]) | (p[2] & p[1] & gn[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = gn[3] | (p[3] & gn[2]) | (p[3] & p[2] & gn[1]) | (p[3] & p[2] & p[1] & gn[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  assign b_eff        = bus.Sub ? ~bus.B : bus.B;
  assign c0           = bus.Sub | bus.Cin;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar g = 0; g < GROUPS; g++) begin : stg
    logic [3:0]     ga;
    logic [3:0]     gb;
    logic           gci;
    logic           gv;
    logic [4:0]     r;
    logic           vld_q;
    logic           cy_q;
    logic [4*g+3:0] sum_q;

    assign r = cla4(ga, gb, gci);

    if (g == 0) begin : head
      assign ga  = bus.A[3:0];
      assign gb  = b_eff[3:0];
      assign gci = c0;
      assign gv  = bus.in_valid;
      always_ff @(posedge clk) begin
        if (rst)      sum_q <= '0;
        else if (adv) sum_q <= r[3:0];
      end
    end else begin : body
      assign ga  = stg[g-1].pend.a_q[3:0];
      assign gb  = stg[g-1].pend.b_q[3:0];
      assign gci = stg[g-1].cy_q;
      assign gv  = stg[g-1].vld_q;
      // lower groups ride along so the whole word leaves together
      always_ff @(posedge clk) begin
        if (rst)      sum_q <= '0;
        else if (adv) sum_q <= {r[3:0], stg[g-1].sum_q};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
      end else if (adv) begin
        vld_q <= gv;
        cy_q  <= r[4];
      end
    end

    // operand groups not yet consumed, skewed by one stage
    if (g < GROUPS-1) begin : pend
      logic [WIDTH-4*g-5:0] a_q;
      logic [WIDTH-4*g-5:0] b_q;
      logic [WIDTH-4*g-5:0] na;
      logic [WIDTH-4*g-5:0] nb;
      if (g == 0) begin : src
        assign na = bus.A[WIDTH-1:4];
        assign nb = b_eff[WIDTH-1:4];
      end else begin : src
        assign na = stg[g-1].pend.a_q[WIDTH-4*g-1:4];
        assign nb = stg[g-1].pend.b_q[WIDTH-4*g-1:4];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= na;
          b_q <= nb;
        end
      end
    end

    if (g == GROUPS-1) begin : tail
      assign bus.out_valid = vld_q;
      assign bus.F         = sum_q;
      assign bus.Cout      = cy_q;
`ifdef CLA_ADDER_OVF_EN
      logic cmsb_q;
      // carry into the MSB recovered from sum bit and operand bits
      always_ff @(posedge clk) begin
        if (rst)      cmsb_q <= 1'b0;
        else if (adv) cmsb_q <= r[3] ^ ga[3] ^ gb[3];
      end
      assign bus.Ovf = cmsb_q ^ cy_q;
`endif
    end
  end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: a 16-bit and a 4-bit instance checked against a scoreboard.
module tb_pipelined_cla_adder;
  typedef struct packed {
    logic [15:0] f;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    exp_t        e;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t q16[$];
  exp_t q4[$];
  logic        stall16 = 1'b0;
  logic [15:0] hold_f16 = '0;
  logic        stall4 = 1'b0;
  logic [3:0]  hold_f4 = '0;

  pipelined_cla_adder_if #(.WIDTH(16)) b16();
  pipelined_cla_adder_if #(.WIDTH(4))  b4();

  pipelined_cla_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  pipelined_cla_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin, input int w);
    logic [15:0] mask, am, bm;
    logic [16:0] s;
    exp_t r;
    mask   = (w == 4) ? 16'h000F : 16'hFFFF;
    am     = a & mask;
    bm     = (sub ? ~b : b) & mask;
    s      = {1'b0, am} + {1'b0, bm} + {16'b0, sub | cin};
    r.f    = s[15:0] & mask;
    r.cout = s[w];
    r.ovf  = (am[w-1] == bm[w-1]) && (r.f[w-1] != am[w-1]);
    return r;
  endfunction

  function automatic vec_t mkv(input logic [15:0] a, input logic [15:0] b, input logic sub,
                               input logic cin, input logic [15:0] f, input logic cout,
                               input logic ovf);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.cin = cin;
    v.e.f = f; v.e.cout = cout; v.e.ovf = ovf;
    return v;
  endfunction

  // Output-side scoreboards and handshake/hold checks, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      q16.delete();
      stall16 = 1'b0;
    end else begin
      check("in_ready16", b16.in_ready, !(b16.out_valid && !b16.out_ready));
      if (stall16) begin
        check("hold_valid16", b16.out_valid, 1);
        check("hold_f16", b16.F, hold_f16);
      end
      stall16  = b16.out_valid && !b16.out_ready;
      hold_f16 = b16.F;
      if (b16.out_valid && b16.out_ready) begin
        if (q16.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious16: result F=%0h emitted, expected none", b16.F);
        end else begin
          e = q16.pop_front();
          check("f16", b16.F, e.f);
          check("cout16", b16.Cout, e.cout);
`ifdef CLA_ADDER_OVF_EN
          check("ovf16", b16.Ovf, e.ovf);
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      q4.delete();
      stall4 = 1'b0;
    end else begin
      check("in_ready4", b4.in_ready, !(b4.out_valid && !b4.out_ready));
      if (stall4) check("hold_f4", b4.F, hold_f4);
      stall4  = b4.out_valid && !b4.out_ready;
      hold_f4 = b4.F;
      if (b4.out_valid && b4.out_ready) begin
        if (q4.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious4: result F=%0h emitted, expected none", b4.F);
        end else begin
          e = q4.pop_front();
          check("f4", {12'b0, b4.F}, e.f);
          check("cout4", b4.Cout, e.cout);
`ifdef CLA_ADDER_OVF_EN
          check("ovf4", b4.Ovf, e.ovf);
`endif
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input bit w4, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic cin, input exp_t e);
    int guard = 0;
    if (w4) begin
      b4.A = a[3:0]; b4.B = b[3:0]; b4.Sub = sub; b4.Cin = cin; b4.in_valid = 1'b1;
    end else begin
      b16.A = a; b16.B = b; b16.Sub = sub; b16.Cin = cin; b16.in_valid = 1'b1;
    end
    #2;
    while (!(w4 ? b4.in_ready : b16.in_ready) && guard < 50) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end else if (w4) q4.push_back(e);
    else q16.push_back(e);
    @(negedge clk);
    if (w4) b4.in_valid = 1'b0;
    else b16.in_valid = 1'b0;
  endtask

  task automatic drain(input bit w4);
    int n = 0;
    while ((w4 ? q4.size() : q16.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (w4) check("drain4", q4.size(), 0);
    else check("drain16", q16.size(), 0);
  endtask

  task automatic lat(input bit w4, input logic [15:0] a, input logic [15:0] b,
                     input logic sub, input logic cin, input int want);
    int l = 1;
    send(w4, a, b, sub, cin, model(a, b, sub, cin, w4 ? 4 : 16));
    #2;
    while (!(w4 ? b4.out_valid : b16.out_valid) && l < 20) begin
      @(negedge clk);
      #2;
      l++;
    end
    if (w4) check("latency4", l, want);
    else check("latency16", l, want);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv16[9];
    vec_t tv4[4];
    logic [15:0] ra, rb;
    logic rs, rc;
    int c_start;

    tv16[0] = mkv(16'h1234, 16'h0FCC, 1'b0, 1'b1, 16'h2201, 1'b0, 1'b0);
    tv16[1] = mkv(16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    tv16[2] = mkv(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    tv16[3] = mkv(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    tv16[4] = mkv(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
    tv16[5] = mkv(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    tv16[6] = mkv(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    tv16[7] = mkv(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    tv16[8] = mkv(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tv4[0]  = mkv(16'h9, 16'h8, 1'b0, 1'b0, 16'h1, 1'b1, 1'b1);
    tv4[1]  = mkv(16'h7, 16'h1, 1'b0, 1'b0, 16'h8, 1'b0, 1'b1);
    tv4[2]  = mkv(16'h3, 16'h5, 1'b1, 1'b0, 16'hE, 1'b0, 1'b0);
    tv4[3]  = mkv(16'hF, 16'h1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    rst = 1'b1;
    b16.in_valid = 1'b0; b16.A = '0; b16.B = '0; b16.Sub = 1'b0; b16.Cin = 1'b0; b16.out_ready = 1'b1;
    b4.in_valid  = 1'b0; b4.A  = '0; b4.B  = '0; b4.Sub  = 1'b0; b4.Cin  = 1'b0; b4.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_out_valid16", b16.out_valid, 0);
    check("rst_f16", b16.F, 0);
    check("rst_cout16", b16.Cout, 0);
    check("rst_in_ready16", b16.in_ready, 1);
    check("rst_out_valid4", b4.out_valid, 0);
    check("rst_f4", b4.F, 0);
`ifdef CLA_ADDER_OVF_EN
    check("rst_ovf16", b16.Ovf, 0);
`endif
    @(negedge clk);

    // directed vectors, back to back
    for (int i = 0; i < 9; i++) send(1'b0, tv16[i].a, tv16[i].b, tv16[i].sub, tv16[i].cin, tv16[i].e);
    drain(1'b0);
    lat(1'b0, 16'h1234, 16'h0FCC, 1'b0, 1'b1, 4);
    drain(1'b0);

    // eight consecutive operations with the consumer stalled in cycles 5-7
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = 16'($urandom_range(0, 65535));
          rb = 16'($urandom_range(0, 65535));
          rs = 1'($urandom_range(0, 1));
          rc = 1'($urandom_range(0, 1));
          send(1'b0, ra, rb, rs, rc, model(ra, rb, rs, rc, 16));
        end
      end
      begin
        repeat (5) @(negedge clk);
        b16.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        b16.out_ready = 1'b1;
      end
    join
    drain(1'b0);

    // reset while three operations are in flight; the third is presented during reset
    send(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0, 16));
    send(1'b0, 16'h3333, 16'h4444, 1'b0, 1'b1, model(16'h3333, 16'h4444, 1'b0, 1'b1, 16));
    b16.A = 16'h5555; b16.B = 16'h0001; b16.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b16.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2;
      check("rst_quiet16", b16.out_valid, 0);
      if (i == 0) begin
        check("post_rst_in_ready16", b16.in_ready, 1);
        check("post_rst_f16", b16.F, 0);
        check("post_rst_cout16", b16.Cout, 0);
      end
      @(negedge clk);
    end
    lat(1'b0, 16'hABCD, 16'h1357, 1'b1, 1'b0, 4);
    drain(1'b0);

    // 4-bit instance
    for (int i = 0; i < 4; i++) send(1'b1, tv4[i].a, tv4[i].b, tv4[i].sub, tv4[i].cin, tv4[i].e);
    drain(1'b1);
    lat(1'b1, 16'h9, 16'h8, 1'b0, 1'b0, 1);
    drain(1'b1);
    c_start = cyc;
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom_range(0, 15));
      rb = 16'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      send(1'b1, ra, rb, rs, rc, model(ra, rb, rs, rc, 4));
    end
    check("throughput4_cycles", cyc - c_start, 16);
    drain(1'b1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the arithmetic datapath. It generalises the 4-bit lookahead adder to WIDTH bits by splitting operands into 4-bit lookahead groups, with one pipeline stage per group. Operands enter and results leave through valid/ready handshakes, so it sustains one operation per cycle behind a stalling consumer. It is intended as the wide add/sub unit feeding the ALU result bus.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4; GROUPS = WIDTH/4.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set {A, B, Sub, Cin} valid.
- in_ready  output  1  block can accept operands this cycle.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- Sub  input  1  1 = compute A - B (B inverted, carry-in forced 1, Cin ignored); 0 = compute A + B + Cin.
- Cin  input  1  carry-in for add mode.
- out_valid  output  1  F/Cout (and Ovf) hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- F  output  WIDTH  sum/difference.
- Cout  output  1  carry out of bit WIDTH-1; in subtract mode 1 = no borrow.
- Ovf  output  1  signed overflow; present only with CLA_ADDER_OVF_EN.

## Operation
- Each group g computes P/G per bit, lookahead carries within the group, and group sum from the carry entering it.
- Pipeline stage g (0..GROUPS-1) registers: the group-g sum, the carry out of group g, a per-stage valid bit, and skewed copies of the not-yet-consumed higher operand groups.
- Lower result groups are delayed through skew registers so that all WIDTH bits of one operation leave together.
- Global advance: adv = !out_valid || out_ready. All stages, including the output register, shift only when adv = 1; otherwise every stage holds.
- in_ready = adv. An operand set is accepted on an edge where in_valid && in_ready.
- Bubbles (in_valid = 0 while adv = 1) propagate as stage valid = 0; F/Cout are don't-care when out_valid = 0, but are held stable while out_valid && !out_ready.
- Arithmetic: {Cout, F} = A + B' + c0 modulo 2^(WIDTH+1), where B' = Sub ? ~B : B and c0 = Sub ? 1 : Cin.

## Timing
- Latency: operand accepted at edge of cycle 0 → result on outputs with out_valid = 1 in cycle GROUPS, assuming no stall. WIDTH=16 gives 4 cycles; WIDTH=4 gives 1 cycle.
- Throughput: one result per cycle while out_ready = 1.
- Stall: each cycle of out_ready = 0 with out_valid = 1 adds exactly one cycle to every in-flight operation. No operation is dropped or duplicated.
- Simultaneous: while the pipe is full and out_ready = 1, a new accept and a result retire on the same edge.
- Reset: while rst is high at an edge, all stage valids and out_valid go to 0, F = 0, Cout = 0, Ovf = 0; in_ready = 1 in the first cycle after reset.
- Reset mid-operation: in-flight operations are discarded without being emitted. Inputs presented in the reset cycle are not accepted.

## Configuration
- CLA_ADDER_OVF_EN defined:
  - the Ovf port exists, with Ovf = carry into bit WIDTH-1 XOR Cout, pipelined alongside F.
  - the last stage additionally registers the carry into the MSB.
- CLA_ADDER_OVF_EN undefined: no Ovf port and no associated logic.

## Test plan
- WIDTH=16, add: A=0x1234, B=0x0FCC, Cin=1, Sub=0 → in cycle 4, F=0x2201, Cout=0, out_valid=1.
- WIDTH=16, carry through every group: A=0xFFFF, B=0x0000, Cin=1 → F=0x0000, Cout=1. With OVF_EN, A=0x7FFF, B=0x0001, Cin=0 → F=0x8000, Ovf=1.
- WIDTH=16, subtract: A=0x0005, B=0x0007, Sub=1, Cin=0 → F=0xFFFE, Cout=0 (borrow). Then A=0x0007, B=0x0005 → F=0x0002, Cout=1.
- Back-to-back with stall: issue 8 random operations on consecutive cycles, hold out_ready=0 for cycles 5–7 → all 8 results appear in order and match the reference sum; in_ready=0 exactly while out_valid && !out_ready; F stays stable during the stall.
- Reset mid-flight: issue 3 operations, assert rst for one cycle at cycle 2 → out_valid stays 0 and no result is ever emitted; the first post-reset operation appears 4 cycles after acceptance.
- WIDTH=4 build: A=0x9, B=0x8, Cin=0 → F=0x1, Cout=1 in cycle 1. Throughput at 1 result per cycle over 16 operations.
